// File: rtl/intf_arb_pkg.sv
// rtl/intf_arb_pkg.sv - shared types and helpers for the round-robin interface arbiter
package intf_arb_pkg;

  localparam int INTF_ARB_MAX_COUNT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // Index after cur, wrapping at n.
  function automatic int wrap_inc(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  localparam int SW = PW + 1;

  logic          found;
  logic [SW-1:0] sum;
  logic [PW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/intf_rr_arbiter.sv
// rtl/intf_rr_arbiter.sv - burst round-robin arbiter onto one shared beat port
// Optional stall timeout enabled by defining INTF_ARB_TIMEOUT_EN.
module intf_rr_arbiter
  import intf_arb_pkg::*;
#(
  parameter int INTF_COUNT = 4,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 8
`ifdef INTF_ARB_TIMEOUT_EN
  , parameter int TIMEOUT  = 64
`endif
) (
  input  logic                         ck1,
  input  logic                         rst_n,
  input  logic [INTF_COUNT-1:0]        req,
  input  logic [INTF_COUNT-1:0]        last,
  input  logic [INTF_COUNT*DATA_W-1:0] data_in,
  output logic [INTF_COUNT-1:0]        gnt,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(INTF_COUNT)-1:0] out_src,
  input  logic                         out_ready,
`ifdef INTF_ARB_TIMEOUT_EN
  output logic                         timeout_err,
`endif
  output logic                         busy
);

  localparam int PW = $clog2(INTF_COUNT);

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         win_q, win_d;
  logic [INTF_COUNT-1:0] gnt_q, gnt_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [8:0]            cnt_inc;
  logic                  burst_end;
  logic                  tmo_hit;

  logic [INTF_COUNT-1:0] pick_oh;
  logic [PW-1:0]         pick_idx;
  logic                  pick_any;

  rr_pick #(
    .N  (INTF_COUNT),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef INTF_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_q, stall_d;

  assign tmo_hit = (state_q == ST_XFER) && req[win_q] && !out_ready &&
                   (stall_q == TW'(TIMEOUT - 1));

  always_ff @(posedge ck1) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  always_comb begin
    stall_d = stall_q;
    if (state_q != ST_XFER || !req[win_q] || out_ready || tmo_hit) stall_d = '0;
    else                                                         stall_d = stall_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge ck1) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    burst_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_XFER;
          win_d   = pick_idx;
          gnt_d   = pick_oh;
          cnt_d   = '0;
        end
      end
      ST_XFER: begin
        // An absent request abandons the burst without counting a beat.
        if (!req[win_q]) begin
          burst_end = 1'b1;
        end else if (out_ready) begin
          cnt_d = cnt_inc[7:0];
          if (last[win_q] || cnt_inc == 9'(MAX_BURST)) burst_end = 1'b1;
        end else if (tmo_hit) begin
          burst_end = 1'b1;
        end
        if (burst_end) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = PW'(wrap_inc(int'(win_q), INTF_COUNT));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    busy      = (state_q == ST_XFER);
    out_valid = 1'b0;
    out_data  = '0;
    out_src   = '0;
    if (state_q == ST_XFER) begin
      out_valid = req[win_q];
      out_data  = data_in[int'(win_q)*DATA_W +: DATA_W];
      out_src   = win_q;
    end
`ifdef INTF_ARB_TIMEOUT_EN
    timeout_err = tmo_hit;
`endif
  end

endmodule

// File: tb/tb_intf_rr_arbiter.sv
// tb/tb_intf_rr_arbiter.sv - directed self-checking bench for intf_rr_arbiter
module tb_intf_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          ck1 = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  gnt;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_ready;
  logic          busy;
`ifdef INTF_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 ck1 = ~ck1;

  intf_rr_arbiter #(
    .INTF_COUNT (N),
    .DATA_W     (DW),
    .MAX_BURST  (8)
`ifdef INTF_ARB_TIMEOUT_EN
    , .TIMEOUT  (4)
`endif
  ) dut (
    .ck1         (ck1),
    .rst_n       (rst_n),
    .req         (req),
    .last        (last),
    .data_in     (data_in),
    .gnt         (gnt),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_ready   (out_ready),
`ifdef INTF_ARB_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck1);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    data_in[i*DW +: DW] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req = '0; last = '0; data_in = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_src", 64'(out_src), 64'h0);
    rst_n = 1'b1;

    // Single requester 2, three beats, non-granted last bits ignored.
    req = 4'b0100; set_data(2, 32'hB1);
    #1 chk("t1_idle_gnt", 64'(gnt), 64'h0);
    tick();
    last = 4'b1011;
    #1;
    chk("t1_gnt", 64'(gnt), 64'h4);
    chk("t1_busy", 64'(busy), 64'h1);
    chk("t1_valid", 64'(out_valid), 64'h1);
    chk("t1_src", 64'(out_src), 64'h2);
    chk("t1_data1", 64'(out_data), 64'hB1);
    tick();
    set_data(2, 32'hB2);
    #1 chk("t1_data2", 64'(out_data), 64'hB2);
    chk("t1_gnt2", 64'(gnt), 64'h4);
    tick();
    set_data(2, 32'hB3); last = 4'b0100;
    #1 chk("t1_data3", 64'(out_data), 64'hB3);
    tick();
    req = '0; last = '0;
    #1;
    chk("t1_end_gnt", 64'(gnt), 64'h0);
    chk("t1_end_busy", 64'(busy), 64'h0);
    chk("t1_end_valid", 64'(out_valid), 64'h0);
    tick();

    // Reset pointer, then all four with single-beat bursts.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b1111; last = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_gnt%0d", k), 64'(gnt), 64'(4'b0001 << (k % 4)));
      chk($sformatf("t2_src%0d", k), 64'(out_src), 64'(k % 4));
      tick();
      if (k == 4) begin req = '0; last = '0; end
      #1 chk($sformatf("t2_gap%0d", k), 64'(gnt), 64'h0);
      tick();
    end

    // Requester 1 held without last: MAX_BURST ends it, pointer moves to 2.
    req = 4'b0010;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_gnt%0d", k), 64'(gnt), 64'h2);
      tick();
    end
    chk("t3_end_gnt", 64'(gnt), 64'h0);
    req = 4'b0110;
    tick();
    chk("t3_ptr2", 64'(gnt), 64'h4);
    last = 4'b0100;
    tick();
    req = '0; last = '0;
    tick();

    // Requester 3: one beat, 5 stalls, then 7 beats fill MAX_BURST.
    req = 4'b1000; set_data(3, 32'hC1);
    tick();
    chk("t4_gnt", 64'(gnt), 64'h8);
    tick();
    out_ready = 1'b0; set_data(3, 32'hC2);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_stall_gnt%0d", k), 64'(gnt), 64'h8);
      chk($sformatf("t4_stall_data%0d", k), 64'(out_data), 64'hC2);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1 chk($sformatf("t4_resume%0d", k), 64'(gnt), 64'h8);
      tick();
    end
    chk("t4_end", 64'(gnt), 64'h0);
    req = '0;
    tick();

    // Reset during beat 2 of a burst from requester 2.
    req = 4'b0100;
    tick(); tick();
    chk("t5_beat2_gnt", 64'(gnt), 64'h4);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_gnt", 64'(gnt), 64'h0);
    chk("t5_rst_busy", 64'(busy), 64'h0);
    rst_n = 1'b1; req = 4'b1010;
    tick();
    chk("t5_ptr0", 64'(gnt), 64'h2);
    req = 4'b0000;
    #1 chk("t5_abandon_valid", 64'(out_valid), 64'h0);
    tick();
    chk("t5_abandon_gnt", 64'(gnt), 64'h0);
    req = 4'b1011;
    tick();
    chk("t5_after_abandon", 64'(gnt), 64'h8);
    req = '0;
    tick();
    tick();

`ifdef INTF_ARB_TIMEOUT_EN
    // TIMEOUT=4 with out_ready held low.
    req = 4'b0001; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_tmo%0d", k), 64'(timeout_err), 64'(k == 3));
      chk($sformatf("t6_gnt%0d", k), 64'(gnt), 64'h1);
      tick();
    end
    chk("t6_cleared", 64'(gnt), 64'h0);
    chk("t6_tmo_off", 64'(timeout_err), 64'h0);
    req = '0; out_ready = 1'b1;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
